dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 15 +
 rtl/dmem_array.sv | 24 ++
 rtl/dmem_responder.sv | 125 ++++++++++++
 tb/tb_dmem_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and default sizing for the data-memory responder.
// Holds the FSM state encoding used by dmem_responder.
package dmem_responder_pkg;

    localparam int DEF_NBITS   = 8;
    localparam int DEF_NWORDS  = 32;
    localparam int DEF_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module dmem_array #(
    parameter int NBITS  = 8,
    parameter int NWORDS = 32
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [$clog2(NWORDS)-1:0] addr_i,
    input  logic [NBITS-1:0]          wdata_i,
    output logic [NBITS-1:0]          rdata_o
);

    logic [NBITS-1:0] mem_q [NWORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: latches a request, waits LATENCY
// cycles, performs the access and presents a one-cycle response.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int NBITS   = DEF_NBITS,
    parameter int NWORDS  = DEF_NWORDS,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [NBITS-1:0] Address,
    input  logic [NBITS-1:0] WriteData,
    output logic [NBITS-1:0] ReadData,
    output logic             busy,
    output logic             err
);

    localparam int AW = $clog2(NWORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [NBITS-1:0] wdata_q, wdata_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             bad_q, bad_d;
    logic [NBITS-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             req;
    logic             mem_we;
    logic [NBITS-1:0] mem_rdata;

    assign req = MemRead | MemWrite;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        bad_d   = bad_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                    idx_d   = Address[AW+1:2];
                    wdata_d = WriteData;
                    rd_d    = MemRead;
                    wr_d    = MemWrite;
                    bad_d   = (Address[1:0] != 2'b00) || (MemRead && MemWrite);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    err_d   = bad_q;
                    // Reset in the final wait cycle must still abort the write.
                    mem_we  = wr_q && !bad_q && !reset;
                    if (bad_q) begin
                        rdata_d = '0;
                    end else if (rd_q) begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        rd_q    <= rd_d;
        wr_q    <= wr_d;
        bad_q   <= bad_d;
    end

    dmem_array #(
        .NBITS  (NBITS),
        .NWORDS (NWORDS)
    ) u_array (
        .clk_i   (clock),
        .we_i    (mem_we),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    assign busy     = !reset && ((state_q == WAIT) || ((state_q == IDLE) && req));
    assign ReadData = rdata_q;
    assign err      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (NBITS=8, NWORDS=32, LATENCY=2).
// Driver pushes expected responses; a negedge monitor pops and compares.
module tb_dmem_responder;

    logic       clock = 1'b0;
    logic       reset;
    logic       MemRead;
    logic       MemWrite;
    logic [7:0] Address;
    logic [7:0] WriteData;
    logic [7:0] ReadData;
    logic       busy;
    logic       err;

    always #5 clock = ~clock;

    dmem_responder #(
        .NBITS   (8),
        .NWORDS  (32),
        .LATENCY (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .busy      (busy),
        .err       (err)
    );

    typedef struct packed {
        logic [7:0] rd;
        logic       er;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   run    = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response cycle = first non-busy cycle after a busy run.
    always @(negedge clock) begin
        if (reset) begin
            check("busy_in_reset", {31'd0, busy}, 32'd0);
            run = 0;
        end else if (busy) begin
            run++;
        end else if (run > 0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got response expected none at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                check("busy_cycles", run, 32'd3);
                check("err_resp", {31'd0, err}, {31'd0, mon_e.er});
                check("rdata_resp", {24'd0, ReadData}, {24'd0, mon_e.rd});
            end
            run = 0;
        end else begin
            check("err_idle", {31'd0, err}, 32'd0);
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wd, input logic [7:0] exp_rd,
                          input logic exp_err, input logic chg,
                          input logic [7:0] addr2);
        int n;
        sb.push_back('{rd: exp_rd, er: exp_err});
        @(posedge clock);
        #1;
        MemRead   = rd;
        MemWrite  = wr;
        Address   = addr;
        WriteData = wd;
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
            if (chg && n == 1) begin
                Address   = addr2;
                WriteData = 8'hEE;
                MemWrite  = 1'b1;
            end
        end while (busy && n < 20);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL access_timeout: got busy after %0d cycles expected idle", n);
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic abort_write(input logic [7:0] addr, input logic [7:0] wd);
        @(posedge clock);
        #1;
        MemWrite  = 1'b1;
        Address   = addr;
        WriteData = wd;
        @(posedge clock);
        #1;
        check("busy_wait", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rdata_after_rst", {24'd0, ReadData}, 32'd0);
        check("err_after_rst", {31'd0, err}, 32'd0);
        reset    = 1'b0;
        MemWrite = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = 8'h00;
        WriteData = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        check("rst_rdata", {24'd0, ReadData}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        access(0, 1, 8'h08, 8'h5A, 8'h00, 0, 0, 8'h00);
        access(1, 0, 8'h08, 8'h00, 8'h5A, 0, 0, 8'h00);

        access(0, 1, 8'h0C, 8'h22, 8'h5A, 0, 0, 8'h00);
        abort_write(8'h0C, 8'h11);
        access(1, 0, 8'h0C, 8'h00, 8'h22, 0, 0, 8'h00);

        access(0, 1, 8'h08, 8'h33, 8'h22, 0, 0, 8'h00);
        access(0, 1, 8'h09, 8'hFF, 8'h00, 1, 0, 8'h00);
        access(1, 0, 8'h08, 8'h00, 8'h33, 0, 0, 8'h00);

        access(0, 1, 8'h04, 8'h99, 8'h33, 0, 0, 8'h00);
        access(1, 1, 8'h04, 8'hAB, 8'h00, 1, 0, 8'h00);
        access(1, 0, 8'h04, 8'h00, 8'h99, 0, 0, 8'h00);

        access(0, 1, 8'h80, 8'h77, 8'h99, 0, 0, 8'h00);
        access(1, 0, 8'h00, 8'h00, 8'h77, 0, 0, 8'h00);

        access(0, 1, 8'h14, 8'h55, 8'h77, 0, 0, 8'h00);
        access(0, 1, 8'h10, 8'h44, 8'h77, 0, 0, 8'h00);
        access(1, 0, 8'h10, 8'h00, 8'h44, 0, 1, 8'h14);
        access(1, 0, 8'h14, 8'h00, 8'h55, 0, 0, 8'h00);

        repeat (3) @(posedge clock);
        #1;
        check("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
